cal_table_builder: RTL and testbench

CAL_TABLE_BUILDER -- requirements
Module: cal_table_builder

---
 rtl/cal_table_builder.sv | 218 +++++++++++++++++++++
 tb/tb_cal_table_builder.sv | 396 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cal_table_builder.sv
// Camera-based LED calibration: each pass shows one ID bit on the LEDs and captures
// a frame; per-pixel thresholded bits are shifted into a NUM_PIXELS x ID_WIDTH table.
module cal_table_builder #(
    parameter int ID_WIDTH     = 11,
    parameter int NUM_PIXELS   = 64800,
    parameter int NUM_CHANNELS = 3,
    parameter int CH_WIDTH     = 8,
    parameter int ADDR_W       = $clog2(NUM_PIXELS),
    parameter int BIDX_W       = (ID_WIDTH > 1) ? $clog2(ID_WIDTH) : 1,
    parameter int SUM_W        = CH_WIDTH + $clog2(NUM_CHANNELS)
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             start,
    input  logic                             abort,
    input  logic                             mode,
    input  logic [SUM_W-1:0]                 threshold,
    output logic                             show_req,
    output logic [BIDX_W-1:0]                bit_index,
    input  logic                             show_ack,
    input  logic                             pix_valid,
    input  logic                             pix_sof,
    input  logic [ADDR_W-1:0]                pix_addr,
    input  logic [NUM_CHANNELS*CH_WIDTH-1:0] pix_data,
    input  logic [ADDR_W-1:0]                rd_addr,
    output logic [ID_WIDTH-1:0]              rd_data,
    output logic                             busy,
    output logic                             done,
    output logic                             err
);

    localparam int MEM_AW = (NUM_PIXELS > 1) ? $clog2(NUM_PIXELS) : 1;
    localparam int CNT_W  = $clog2(NUM_PIXELS + 1);
    localparam logic [ADDR_W:0]     ADDR_LIM  = (ADDR_W + 1)'(NUM_PIXELS);
    localparam logic [CNT_W-1:0]    CNT_LAST  = CNT_W'(NUM_PIXELS);
    localparam logic [BIDX_W-1:0]   BIDX_LAST = BIDX_W'(ID_WIDTH - 1);

    typedef enum logic [2:0] {IDLE, SHOW, WAIT_SOF, CAPTURE, DRAIN, DONE} state_t;

    state_t state, state_next;

    logic [ID_WIDTH-1:0] mem [NUM_PIXELS];

    logic [SUM_W-1:0]  thr_q;
    logic              mode_q;
    logic [CNT_W-1:0]  pix_cnt;
    logic [CNT_W-1:0]  pix_cnt_inc;
    logic              drain_cnt;

    logic              run_start, pix_take, cnt_first, cnt_inc, flag_err, pass_next, finish;

    logic [SUM_W-1:0]  ch_sum;
    logic              any_hi;
    logic              pix_bit;
    logic              addr_ok;
    logic [MEM_AW-1:0] pix_idx;

    logic              p1_valid, p2_valid;
    logic [MEM_AW-1:0] p1_addr, p2_addr;
    logic              p1_bit, p2_bit;
    logic              p1_first, p2_first;
    logic [ID_WIDTH-1:0] p1_old, p2_old;
    logic [ID_WIDTH-1:0] old_eff, wr_word;

    logic [ID_WIDTH-1:0] rd_q1;
    logic              rd_ok_q, rd_v1;

    assign pix_idx     = pix_addr[MEM_AW-1:0];
    assign addr_ok     = {1'b0, pix_addr} < ADDR_LIM;
    assign pix_cnt_inc = pix_cnt + CNT_W'(1);

    assign show_req = (state == SHOW);
    assign busy     = (state == SHOW) || (state == WAIT_SOF) ||
                      (state == CAPTURE) || (state == DRAIN);

    always_comb begin
        ch_sum = '0;
        any_hi = 1'b0;
        for (int c = 0; c < NUM_CHANNELS; c++) begin
            ch_sum = ch_sum + SUM_W'(pix_data[c*CH_WIDTH +: CH_WIDTH]);
            any_hi = any_hi | (SUM_W'(pix_data[c*CH_WIDTH +: CH_WIDTH]) > thr_q);
        end
        pix_bit = mode_q ? any_hi : (ch_sum > thr_q);
    end

    // show_req is held in SHOW until show_ack; pixels have no backpressure and are
    // taken on every cycle pix_valid is high while the FSM is capturing.
    always_comb begin
        state_next = state;
        run_start  = 1'b0;
        pix_take   = 1'b0;
        cnt_first  = 1'b0;
        cnt_inc    = 1'b0;
        flag_err   = 1'b0;
        pass_next  = 1'b0;
        finish     = 1'b0;
        case (state)
            IDLE, DONE: begin
                if (start) begin
                    state_next = SHOW;
                    run_start  = 1'b1;
                end
            end
            SHOW: begin
                if (abort) begin
                    state_next = DRAIN;
                    flag_err   = 1'b1;
                end else if (show_ack) begin
                    state_next = WAIT_SOF;
                end
            end
            WAIT_SOF: begin
                if (abort) begin
                    state_next = DRAIN;
                    flag_err   = 1'b1;
                end else if (pix_valid && pix_sof) begin
                    pix_take   = 1'b1;
                    cnt_first  = 1'b1;
                    state_next = (CNT_W'(1) == CNT_LAST) ? DRAIN : CAPTURE;
                end
            end
            CAPTURE: begin
                if (abort) begin
                    state_next = DRAIN;
                    flag_err   = 1'b1;
                end else if (pix_valid && pix_sof) begin
                    state_next = DRAIN;
                    flag_err   = 1'b1;
                end else if (pix_valid) begin
                    pix_take = 1'b1;
                    cnt_inc  = 1'b1;
                    if (pix_cnt_inc == CNT_LAST) state_next = DRAIN;
                end
            end
            DRAIN: begin
                flag_err = abort;
                // Two drain cycles cover the read-to-write distance of the update pipe.
                if (drain_cnt) begin
                    if (err || abort || (bit_index == BIDX_LAST)) begin
                        state_next = DONE;
                        finish     = 1'b1;
                    end else begin
                        state_next = SHOW;
                        pass_next  = 1'b1;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bit_index <= '0;
            pix_cnt   <= '0;
            drain_cnt <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
            thr_q     <= '0;
            mode_q    <= 1'b0;
        end else begin
            drain_cnt <= (state == DRAIN) && !drain_cnt;
            if (run_start) begin
                done      <= 1'b0;
                err       <= 1'b0;
                bit_index <= '0;
                thr_q     <= threshold;
                mode_q    <= mode;
            end
            if (flag_err)  err       <= 1'b1;
            if (finish)    done      <= 1'b1;
            if (pass_next) bit_index <= bit_index + BIDX_W'(1);
            if (cnt_first)    pix_cnt <= CNT_W'(1);
            else if (cnt_inc) pix_cnt <= pix_cnt_inc;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p1_valid <= 1'b0;
            p2_valid <= 1'b0;
            rd_v1    <= 1'b0;
            rd_ok_q  <= 1'b0;
            rd_data  <= '0;
        end else begin
            p1_valid <= pix_take && addr_ok;
            p2_valid <= p1_valid;
            rd_v1    <= 1'b1;
            rd_ok_q  <= {1'b0, rd_addr} < ADDR_LIM;
            rd_data  <= (rd_v1 && rd_ok_q) ? rd_q1 : '0;
        end
    end

    // Pass 0 ignores whatever the table held, so no clear sweep is needed.
    always_comb begin
        old_eff = p2_first ? '0 : p2_old;
        wr_word = (old_eff << 1) | ID_WIDTH'(p2_bit);
    end

    always_ff @(posedge clk) begin
        p1_old   <= mem[pix_idx];
        p1_addr  <= pix_idx;
        p1_bit   <= pix_bit;
        p1_first <= (bit_index == '0);
        p2_old   <= p1_old;
        p2_addr  <= p1_addr;
        p2_bit   <= p1_bit;
        p2_first <= p1_first;
        rd_q1    <= mem[rd_addr[MEM_AW-1:0]];
        if (p2_valid) mem[p2_addr] <= wr_word;
    end

endmodule

// File: tb/tb_cal_table_builder.sv
// Directed bench for cal_table_builder with a 4-pixel, 3-bit table: full runs,
// threshold modes, framing error, handshake/filtering, abort/restart and reset.
module tb_cal_table_builder;

    localparam int IDW = 3;
    localparam int NP  = 4;
    localparam int NC  = 3;
    localparam int CW  = 8;
    localparam int AW  = 3;
    localparam int BW  = 2;
    localparam int SW  = 10;

    typedef logic [NC*CW-1:0] frame_t [NP];

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    logic              abort = 1'b0;
    logic              mode = 1'b0;
    logic [SW-1:0]     threshold = '0;
    logic              show_req;
    logic [BW-1:0]     bit_index;
    logic              show_ack = 1'b0;
    logic              pix_valid = 1'b0;
    logic              pix_sof = 1'b0;
    logic [AW-1:0]     pix_addr = '0;
    logic [NC*CW-1:0]  pix_data = '0;
    logic [AW-1:0]     rd_addr = '0;
    logic [IDW-1:0]    rd_data;
    logic              busy;
    logic              done;
    logic              err;

    int errors = 0;
    int checks = 0;

    frame_t fa0, fa1, fa2, fb0, fb1, fb2, fm, ff0;

    cal_table_builder #(
        .ID_WIDTH(IDW), .NUM_PIXELS(NP), .NUM_CHANNELS(NC), .CH_WIDTH(CW), .ADDR_W(AW)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .mode(mode),
        .threshold(threshold), .show_req(show_req), .bit_index(bit_index),
        .show_ack(show_ack), .pix_valid(pix_valid), .pix_sof(pix_sof),
        .pix_addr(pix_addr), .pix_data(pix_data), .rd_addr(rd_addr), .rd_data(rd_data),
        .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [NC*CW-1:0] px(input int c0, input int c1, input int c2);
        return {8'(c2), 8'(c1), 8'(c0)};
    endfunction

    function automatic logic ref_bit(input logic m, input int thr, input logic [NC*CW-1:0] d);
        int  s;
        logic a;
        s = 0;
        a = 1'b0;
        for (int c = 0; c < NC; c++) begin
            s = s + int'(d[c*CW +: CW]);
            if (int'(d[c*CW +: CW]) > thr) a = 1'b1;
        end
        return m ? a : (s > thr);
    endfunction

    function automatic logic [IDW-1:0] ref_word(input logic m, input int thr,
                                                input frame_t f0, input frame_t f1,
                                                input frame_t f2, input int a);
        return {ref_bit(m, thr, f0[a]), ref_bit(m, thr, f1[a]), ref_bit(m, thr, f2[a])};
    endfunction

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic send_pix(input int a, input logic s, input logic [NC*CW-1:0] d);
        pix_valid = 1'b1;
        pix_sof   = s;
        pix_addr  = AW'(a);
        pix_data  = d;
        tick();
        pix_valid = 1'b0;
        pix_sof   = 1'b0;
    endtask

    task automatic send_frame(input frame_t f);
        for (int i = 0; i < NP; i++) send_pix(i, (i == 0), f[i]);
    endtask

    task automatic wait_show();
        int n;
        n = 0;
        while (!show_req && n < 100) begin
            tick();
            n++;
        end
        if (!show_req) begin
            checks++;
            errors++;
            $display("FAIL wait_show: show_req=%0b, required 1 within 100 cycles", show_req);
        end
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while (!done && n < 100) begin
            tick();
            n++;
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL wait_done: done=%0b, required 1 within 100 cycles", done);
        end
    endtask

    task automatic ack();
        show_ack = 1'b1;
        tick();
        show_ack = 1'b0;
    endtask

    task automatic do_start(input logic m, input int thr);
        start     = 1'b1;
        mode      = m;
        threshold = SW'(thr);
        tick();
        start     = 1'b0;
    endtask

    task automatic read_word(input int a, output logic [IDW-1:0] v);
        rd_addr = AW'(a);
        tick();
        tick();
        v = rd_data;
    endtask

    task automatic run_passes(input frame_t f0, input frame_t f1, input frame_t f2);
        wait_show(); ack(); send_frame(f0);
        wait_show(); ack(); send_frame(f1);
        wait_show(); ack(); send_frame(f2);
        wait_done();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick(); tick();
        checks += 6;
        if (busy !== 1'b0)      begin errors++; $display("FAIL reset_busy: got %0b want 0", busy); end
        if (done !== 1'b0)      begin errors++; $display("FAIL reset_done: got %0b want 0", done); end
        if (err !== 1'b0)       begin errors++; $display("FAIL reset_err: got %0b want 0", err); end
        if (show_req !== 1'b0)  begin errors++; $display("FAIL reset_show_req: got %0b want 0", show_req); end
        if (bit_index !== '0)   begin errors++; $display("FAIL reset_bit_index: got %0d want 0", bit_index); end
        if (rd_data !== '0)     begin errors++; $display("FAIL reset_rd_data: got %0d want 0", rd_data); end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_full_run();
        logic [IDW-1:0] v, e;
        do_start(1'b0, 100);
        run_passes(fa0, fa1, fa2);
        checks += 2;
        if (done !== 1'b1) begin errors++; $display("FAIL full_done: got %0b want 1", done); end
        if (err !== 1'b0)  begin errors++; $display("FAIL full_err: got %0b want 0", err); end
        for (int a = 0; a < NP; a++) begin
            read_word(a, v);
            e = ref_word(1'b0, 100, fa0, fa1, fa2, a);
            checks++;
            if (v !== e) begin errors++; $display("FAIL full_table[%0d]: got %0d want %0d", a, v, e); end
        end
    endtask

    task automatic test_handshake();
        logic [IDW-1:0] v;
        logic low_seen;
        logic [IDW-1:0] exp_tab [NP];
        exp_tab = '{3'd1, 3'd0, 3'd1, 3'd0};
        do_start(1'b0, 100);
        low_seen  = 1'b0;
        pix_valid = 1'b1;
        pix_sof   = 1'b1;
        pix_addr  = AW'(3);
        pix_data  = px(200, 0, 0);
        for (int i = 0; i < 50; i++) begin
            if (show_req !== 1'b1) low_seen = 1'b1;
            tick();
        end
        pix_valid = 1'b0;
        pix_sof   = 1'b0;
        checks += 2;
        if (low_seen !== 1'b0) begin errors++; $display("FAIL hs_show_req_held: dropped=%0b want 0", low_seen); end
        if (busy !== 1'b1)     begin errors++; $display("FAIL hs_busy: got %0b want 1", busy); end
        read_word(3, v);
        checks++;
        if (v !== 3'd0) begin errors++; $display("FAIL hs_no_write_in_show: got %0d want 0", v); end
        ack();
        for (int i = 0; i < 3; i++) send_pix(3, 1'b0, px(200, 0, 0));
        pix_sof = 1'b1;
        tick();
        pix_sof = 1'b0;
        send_pix(0, 1'b1, px(200, 0, 0));
        send_pix(7, 1'b0, px(200, 0, 0));
        send_pix(1, 1'b0, px(0, 0, 0));
        send_pix(2, 1'b0, px(0, 200, 0));
        checks += 2;
        if (busy !== 1'b1)     begin errors++; $display("FAIL hs_drain_busy: got %0b want 1", busy); end
        if (show_req !== 1'b0) begin errors++; $display("FAIL hs_drain_show_req: got %0b want 0", show_req); end
        tick(); tick();
        checks += 2;
        if (show_req !== 1'b1)  begin errors++; $display("FAIL hs_next_pass_show: got %0b want 1", show_req); end
        if (bit_index !== 2'd1) begin errors++; $display("FAIL hs_next_bit_index: got %0d want 1", bit_index); end
        abort = 1'b1;
        tick();
        abort = 1'b0;
        wait_done();
        checks++;
        if (err !== 1'b1) begin errors++; $display("FAIL hs_abort_err: got %0b want 1", err); end
        for (int a = 0; a < NP; a++) begin
            read_word(a, v);
            checks++;
            if (v !== exp_tab[a]) begin errors++; $display("FAIL hs_table[%0d]: got %0d want %0d", a, v, exp_tab[a]); end
        end
    endtask

    task automatic test_modes();
        logic [IDW-1:0] v;
        logic [IDW-1:0] exp1 [NP];
        logic [IDW-1:0] exp0 [NP];
        exp1 = '{3'd7, 3'd0, 3'd7, 3'd0};
        exp0 = '{3'd7, 3'd7, 3'd7, 3'd7};
        do_start(1'b1, 100);
        run_passes(fm, fm, fm);
        for (int a = 0; a < NP; a++) begin
            read_word(a, v);
            checks++;
            if (v !== exp1[a]) begin errors++; $display("FAIL mode1_table[%0d]: got %0d want %0d", a, v, exp1[a]); end
        end
        do_start(1'b0, 100);
        run_passes(fm, fm, fm);
        for (int a = 0; a < NP; a++) begin
            read_word(a, v);
            checks++;
            if (v !== exp0[a]) begin errors++; $display("FAIL mode0_table[%0d]: got %0d want %0d", a, v, exp0[a]); end
        end
    endtask

    task automatic test_framing();
        logic [IDW-1:0] v;
        logic [IDW-1:0] exp_tab [NP];
        exp_tab = '{3'd2, 3'd1, 3'd1, 3'd1};
        do_start(1'b0, 100);
        wait_show(); ack(); send_frame(ff0);
        wait_show(); ack();
        send_pix(0, 1'b1, px(0, 0, 0));
        send_pix(1, 1'b0, px(200, 0, 0));
        send_pix(2, 1'b1, px(200, 0, 0));
        wait_done();
        checks += 4;
        if (err !== 1'b1)       begin errors++; $display("FAIL frm_err: got %0b want 1", err); end
        if (done !== 1'b1)      begin errors++; $display("FAIL frm_done: got %0b want 1", done); end
        if (bit_index !== 2'd1) begin errors++; $display("FAIL frm_bit_index: got %0d want 1", bit_index); end
        if (busy !== 1'b0)      begin errors++; $display("FAIL frm_busy: got %0b want 0", busy); end
        for (int a = 0; a < NP; a++) begin
            read_word(a, v);
            checks++;
            if (v !== exp_tab[a]) begin errors++; $display("FAIL frm_table[%0d]: got %0d want %0d", a, v, exp_tab[a]); end
        end
    endtask

    task automatic test_abort_restart();
        logic [IDW-1:0] v, e;
        do_start(1'b0, 100);
        wait_show(); ack(); send_frame(fa0);
        wait_show(); ack();
        start = 1'b1;
        tick();
        start = 1'b0;
        checks += 2;
        if (bit_index !== 2'd1) begin errors++; $display("FAIL ar_start_ignored_bidx: got %0d want 1", bit_index); end
        if (busy !== 1'b1)      begin errors++; $display("FAIL ar_start_ignored_busy: got %0b want 1", busy); end
        send_frame(fa1);
        wait_show();
        checks++;
        if (bit_index !== 2'd2) begin errors++; $display("FAIL ar_pass2_bidx: got %0d want 2", bit_index); end
        ack();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        checks += 2;
        if (busy !== 1'b1) begin errors++; $display("FAIL ar_drain1_busy: got %0b want 1", busy); end
        if (done !== 1'b0) begin errors++; $display("FAIL ar_drain1_done: got %0b want 0", done); end
        tick();
        checks += 2;
        if (busy !== 1'b1) begin errors++; $display("FAIL ar_drain2_busy: got %0b want 1", busy); end
        if (done !== 1'b0) begin errors++; $display("FAIL ar_drain2_done: got %0b want 0", done); end
        tick();
        checks += 3;
        if (done !== 1'b1) begin errors++; $display("FAIL ar_done: got %0b want 1", done); end
        if (err !== 1'b1)  begin errors++; $display("FAIL ar_err: got %0b want 1", err); end
        if (busy !== 1'b0) begin errors++; $display("FAIL ar_idle_busy: got %0b want 0", busy); end
        start     = 1'b1;
        abort     = 1'b1;
        mode      = 1'b0;
        threshold = SW'(100);
        tick();
        start = 1'b0;
        abort = 1'b0;
        checks += 4;
        if (busy !== 1'b1)     begin errors++; $display("FAIL ar_restart_busy: got %0b want 1", busy); end
        if (err !== 1'b0)      begin errors++; $display("FAIL ar_restart_err: got %0b want 0", err); end
        if (done !== 1'b0)     begin errors++; $display("FAIL ar_restart_done: got %0b want 0", done); end
        if (show_req !== 1'b1) begin errors++; $display("FAIL ar_restart_show: got %0b want 1", show_req); end
        run_passes(fb0, fb1, fb2);
        checks += 2;
        if (done !== 1'b1) begin errors++; $display("FAIL ar_run_done: got %0b want 1", done); end
        if (err !== 1'b0)  begin errors++; $display("FAIL ar_run_err: got %0b want 0", err); end
        for (int a = 0; a < NP; a++) begin
            read_word(a, v);
            e = ref_word(1'b0, 100, fb0, fb1, fb2, a);
            checks++;
            if (v !== e) begin errors++; $display("FAIL ar_table[%0d]: got %0d want %0d", a, v, e); end
        end
    endtask

    task automatic test_async_reset();
        logic [IDW-1:0] v, e, keep;
        keep = ref_word(1'b0, 100, fb0, fb1, fb2, 0);
        do_start(1'b0, 100);
        wait_show(); ack();
        send_pix(0, 1'b1, px(200, 0, 0));
        send_pix(1, 1'b0, px(200, 0, 0));
        #2;
        rst_n = 1'b0;
        #1;
        checks += 5;
        if (busy !== 1'b0)     begin errors++; $display("FAIL ares_busy: got %0b want 0", busy); end
        if (show_req !== 1'b0) begin errors++; $display("FAIL ares_show_req: got %0b want 0", show_req); end
        if (bit_index !== '0)  begin errors++; $display("FAIL ares_bit_index: got %0d want 0", bit_index); end
        if (done !== 1'b0)     begin errors++; $display("FAIL ares_done: got %0b want 0", done); end
        if (rd_data !== '0)    begin errors++; $display("FAIL ares_rd_data: got %0d want 0", rd_data); end
        tick();
        rd_addr = '0;
        tick();
        rst_n = 1'b1;
        tick();
        checks++;
        if (rd_data !== '0) begin errors++; $display("FAIL ares_rd_after_release: got %0d want 0", rd_data); end
        tick();
        checks++;
        if (rd_data !== keep) begin errors++; $display("FAIL ares_table_kept: got %0d want %0d", rd_data, keep); end
        do_start(1'b0, 100);
        run_passes(fa0, fa1, fa2);
        checks += 2;
        if (done !== 1'b1) begin errors++; $display("FAIL ares_run_done: got %0b want 1", done); end
        if (err !== 1'b0)  begin errors++; $display("FAIL ares_run_err: got %0b want 0", err); end
        for (int a = 0; a < NP; a++) begin
            read_word(a, v);
            e = ref_word(1'b0, 100, fa0, fa1, fa2, a);
            checks++;
            if (v !== e) begin errors++; $display("FAIL ares_table[%0d]: got %0d want %0d", a, v, e); end
        end
    endtask

    initial begin
        // Channel sums 200/0/150/0, 200/200/0/0, 0/200/150/0
        fa0 = '{px(100, 50, 50), px(0, 0, 0),     px(50, 50, 50), px(0, 0, 0)};
        fa1 = '{px(100, 50, 50), px(0, 0, 200),   px(0, 0, 0),    px(0, 0, 0)};
        fa2 = '{px(0, 0, 0),     px(60, 70, 70),  px(50, 50, 50), px(0, 0, 0)};
        // Sums sitting on and just above the threshold, plus the widest possible sum
        fb0 = '{px(50, 50, 0),   px(34, 33, 34),  px(0, 0, 0),    px(255, 255, 255)};
        fb1 = '{px(34, 33, 34),  px(0, 0, 0),     px(0, 0, 0),    px(255, 0, 0)};
        fb2 = '{px(255, 255, 255), px(50, 50, 0), px(0, 0, 0),    px(0, 0, 0)};
        fm  = '{px(101, 0, 0),   px(50, 50, 50),  px(0, 0, 101),  px(100, 100, 100)};
        ff0 = '{px(200, 0, 0),   px(0, 0, 0),     px(0, 200, 0),  px(0, 0, 200)};
        tick();
        test_reset();
        test_full_run();
        test_handshake();
        test_modes();
        test_framing();
        test_abort_restart();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
